audio_mix_sched: RTL and testbench

Frame scheduler for `audio_mixer_8_16bps`, acting as the only master on the mixer's `a_mix_wif_t` register port.
- Turns DAC half-buffer requests into mixer runs over a ping-pong output buffer: programs the master address and length, starts the mix and waits for completion.
- Queues CPU channel-register writes and applies them only between frames, so channel updates never land mid-mix.

---
 rtl/audio_mix_pkg.sv | 32 +++
 rtl/audio_cmd_fifo.sv | 62 ++++++
 rtl/audio_mix_sched.sv | 171 +++++++++++++++++
 tb/tb_audio_mix_sched.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/audio_mix_pkg.sv
// audio_mix_pkg: shared definitions for the mixer frame scheduler.
//   - Mixer register addresses used by the scheduler.
//   - a_cmd_t: one queued CPU channel-register write.
//   - sched_state_e: scheduler FSM states.
package audio_mix_pkg;

  localparam logic [7:0] MIX_REG_MADDR  = 8'h00;
  localparam logic [7:0] MIX_REG_MLEN   = 8'h01;
  localparam logic [7:0] MIX_REG_STATUS = 8'h0a;
  localparam logic [7:0] MIX_REG_CTRL   = 8'h40;

  typedef struct packed {
    logic [7:0]  addr;
    logic [31:0] dat;
  } a_cmd_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_MADDR,
    S_MLEN,
    S_START,
    S_WAIT_BUSY,
    S_WAIT_DONE
  } sched_state_e;

  // Only the channel register bank (addr[7] set) may be written by the CPU.
  function automatic logic is_chan_reg(input logic [7:0] addr);
    return addr[7];
  endfunction

endpackage

// File: rtl/audio_cmd_fifo.sv
// audio_cmd_fifo: small synchronous FIFO of a_cmd_t entries.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   push_i, din_i : write side (push ignored when full unless popping)
//   pop_i, head_o : read side; head_o shows the oldest entry (first-word fall-through)
//   empty_o       : registered empty flag
//   ready_o       : registered "not full" flag
// Pointers carry one extra MSB so full and empty are told apart on wrap.
module audio_cmd_fifo
  import audio_mix_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic   clk_i,
  input  logic   rst_ni,
  input  logic   push_i,
  input  a_cmd_t din_i,
  input  logic   pop_i,
  output a_cmd_t head_o,
  output logic   empty_o,
  output logic   ready_o
);

  localparam int AW = $clog2(DEPTH);

  a_cmd_t     mem [DEPTH];
  logic [AW:0] wptr_reg, rptr_reg;
  logic [AW:0] wptr_next, rptr_next;
  logic        full_reg, full_next;
  logic        push_ok, pop_ok;

  assign pop_ok    = pop_i && !empty_o;
  // A pop frees a slot in the same cycle, so a full FIFO can still accept.
  assign push_ok   = push_i && (!full_reg || pop_ok);
  assign wptr_next = wptr_reg + {{AW{1'b0}}, push_ok};
  assign rptr_next = rptr_reg + {{AW{1'b0}}, pop_ok};
  assign full_next = (wptr_next[AW] != rptr_next[AW]) &&
                     (wptr_next[AW-1:0] == rptr_next[AW-1:0]);

  // Tiny storage: a combinational head read keeps the pop path single-cycle.
  assign head_o = mem[rptr_reg[AW-1:0]];

  always_ff @(posedge clk_i) begin
    if (push_ok) mem[wptr_reg[AW-1:0]] <= din_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_reg <= '0;
      rptr_reg <= '0;
      empty_o  <= 1'b1;
      full_reg <= 1'b0;
      ready_o  <= 1'b1;
    end else begin
      wptr_reg <= wptr_next;
      rptr_reg <= rptr_next;
      empty_o  <= (wptr_next == rptr_next);
      full_reg <= full_next;
      ready_o  <= !full_next;
    end
  end

endmodule

// File: rtl/audio_mix_sched.sv
// audio_mix_sched: frame scheduler, sole master of the mixer register port.
//   clk_i, rst_ni           : clock, asynchronous active-low reset
//   en_i, frame_req_i       : frame enable, DAC half-buffer drained pulse
//   cmd_valid_i/ready_o, cmd_addr_i, cmd_dat_i : CPU channel-register writes (queued)
//   mix_stb_o, mix_we_o, mix_addr_o, mix_dat_o : mixer register write (we=0 is write)
//   mix_stb_i, mix_cyc_i    : mixer strobe echo, mixer busy
//   busy_o, frame_done_o, frame_half_o, frames_o : status
//   overrun_o, err_o        : sticky error flags
// Queued commands are only issued from IDLE, so they never land mid-mix.
module audio_mix_sched
  import audio_mix_pkg::*;
#(
  parameter int          FRAME_LEN  = 256,
  parameter logic [31:0] BUF_BASE   = 32'h0,
  parameter int          CMDQ_DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        en_i,
  input  logic        frame_req_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic [7:0]  cmd_addr_i,
  input  logic [31:0] cmd_dat_i,
  output logic        mix_stb_o,
  output logic        mix_we_o,
  output logic [7:0]  mix_addr_o,
  output logic [31:0] mix_dat_o,
  input  logic        mix_stb_i,
  input  logic        mix_cyc_i,
  output logic        busy_o,
  output logic        frame_done_o,
  output logic        frame_half_o,
  output logic [15:0] frames_o,
  output logic        overrun_o,
  output logic        err_o
);

  sched_state_e state_reg;
  logic         pending_reg;
  logic [1:0]   tmo_reg;
  a_cmd_t       q_head;
  logic         q_empty;
  logic         cmd_push, cmd_pop, frame_start, half_eff, wr_ack;
  logic [31:0]  maddr;

  assign cmd_push    = cmd_valid_i && cmd_ready_o;
  assign cmd_pop     = (state_reg == S_IDLE) && !q_empty;
  assign frame_start = (state_reg == S_IDLE) && q_empty && pending_reg && en_i;
  // Echo only counts once our strobe cycle is over.
  assign wr_ack      = !mix_stb_o && mix_stb_i;
  // frame_half_o toggles the cycle after frame_done_o; a frame started in
  // that very cycle must already target the other half.
  assign half_eff    = frame_half_o ^ frame_done_o;
  assign maddr       = BUF_BASE + (half_eff ? 32'(FRAME_LEN) : 32'd0);
  assign busy_o      = (state_reg != S_IDLE);

  audio_cmd_fifo #(.DEPTH(CMDQ_DEPTH)) u_cmd_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (cmd_push),
    .din_i   ('{addr: cmd_addr_i, dat: cmd_dat_i}),
    .pop_i   (cmd_pop),
    .head_o  (q_head),
    .empty_o (q_empty),
    .ready_o (cmd_ready_o)
  );

  // Request latch. A request coinciding with the clear re-arms it cleanly.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pending_reg <= 1'b0;
      overrun_o   <= 1'b0;
    end else if (frame_start) begin
      pending_reg <= frame_req_i;
    end else if (frame_req_i) begin
      pending_reg <= 1'b1;
      if (pending_reg) overrun_o <= 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg    <= S_IDLE;
      mix_stb_o    <= 1'b0;
      mix_we_o     <= 1'b1;
      mix_addr_o   <= '0;
      mix_dat_o    <= '0;
      frame_done_o <= 1'b0;
      frame_half_o <= 1'b0;
      frames_o     <= '0;
      err_o        <= 1'b0;
      tmo_reg      <= '0;
    end else begin
      mix_stb_o    <= 1'b0;
      frame_done_o <= 1'b0;
      if (frame_done_o) frame_half_o <= ~frame_half_o;

      case (state_reg)
        S_IDLE: begin
          if (cmd_pop) begin
            // Illegal commands are latched but never strobed.
            state_reg  <= S_CMD;
            mix_addr_o <= q_head.addr;
            mix_dat_o  <= q_head.dat;
            mix_stb_o  <= is_chan_reg(q_head.addr);
            mix_we_o   <= !is_chan_reg(q_head.addr);
          end else if (frame_start) begin
            state_reg  <= S_MADDR;
            mix_addr_o <= MIX_REG_MADDR;
            mix_dat_o  <= maddr;
            mix_stb_o  <= 1'b1;
            mix_we_o   <= 1'b0;
          end
        end
        S_CMD: begin
          if (!is_chan_reg(mix_addr_o)) begin
            err_o     <= 1'b1;
            state_reg <= S_IDLE;
          end else if (wr_ack) begin
            mix_we_o  <= 1'b1;
            state_reg <= S_IDLE;
          end
        end
        S_MADDR: begin
          if (wr_ack) begin
            state_reg  <= S_MLEN;
            mix_addr_o <= MIX_REG_MLEN;
            mix_dat_o  <= 32'(FRAME_LEN);
            mix_stb_o  <= 1'b1;
          end
        end
        S_MLEN: begin
          if (wr_ack) begin
            state_reg  <= S_START;
            mix_addr_o <= MIX_REG_CTRL;
            mix_dat_o  <= 32'd1;
            mix_stb_o  <= 1'b1;
          end
        end
        S_START: begin
          if (wr_ack) begin
            mix_we_o  <= 1'b1;
            tmo_reg   <= '0;
            state_reg <= S_WAIT_BUSY;
          end
        end
        S_WAIT_BUSY: begin
          if (mix_cyc_i) begin
            state_reg <= S_WAIT_DONE;
          end else if (tmo_reg == 2'd3) begin
            err_o     <= 1'b1;
            state_reg <= S_IDLE;
          end else begin
            tmo_reg <= tmo_reg + 2'd1;
          end
        end
        S_WAIT_DONE: begin
          // Entered only after busy was seen high, so low here is the fall.
          if (!mix_cyc_i) begin
            frame_done_o <= 1'b1;
            frames_o     <= frames_o + 16'd1;
            state_reg    <= S_IDLE;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_audio_mix_sched.sv
module tb_audio_mix_sched;
  import audio_mix_pkg::*;

  localparam logic [31:0] BASE = 32'h0000_2000;
  localparam int          FLEN = 256;

  logic        clk_i = 1'b0;
  logic        rst_ni, en_i, frame_req_i, cmd_valid_i, cmd_ready_o;
  logic [7:0]  cmd_addr_i;
  logic [31:0] cmd_dat_i;
  logic        mix_stb_o, mix_we_o, mix_stb_i, mix_cyc_i;
  logic [7:0]  mix_addr_o;
  logic [31:0] mix_dat_o;
  logic        busy_o, frame_done_o, frame_half_o, overrun_o, err_o;
  logic [15:0] frames_o;

  always #5 clk_i = ~clk_i;

  audio_mix_sched #(.FRAME_LEN(FLEN), .BUF_BASE(BASE), .CMDQ_DEPTH(4)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .en_i(en_i), .frame_req_i(frame_req_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_addr_i(cmd_addr_i), .cmd_dat_i(cmd_dat_i),
    .mix_stb_o(mix_stb_o), .mix_we_o(mix_we_o), .mix_addr_o(mix_addr_o),
    .mix_dat_o(mix_dat_o), .mix_stb_i(mix_stb_i), .mix_cyc_i(mix_cyc_i),
    .busy_o(busy_o), .frame_done_o(frame_done_o), .frame_half_o(frame_half_o),
    .frames_o(frames_o), .overrun_o(overrun_o), .err_o(err_o)
  );

  // Mixer model: echoes the strobe one cycle later; a CTRL write of 1 makes
  // it busy for 20 cycles unless model_dead is set.
  logic        model_dead;
  int unsigned busy_cnt;
  assign mix_cyc_i = (busy_cnt != 0);

  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mix_stb_i <= 1'b0;
      busy_cnt  <= 0;
    end else begin
      mix_stb_i <= mix_stb_o;
      if (mix_stb_o && !mix_we_o && mix_addr_o == MIX_REG_CTRL && mix_dat_o[0] && !model_dead)
        busy_cnt <= 20;
      else if (busy_cnt != 0)
        busy_cnt <= busy_cnt - 1;
    end
  end

  // Bus monitor: stamps are edge counts; an output registered at edge k is
  // stamped k+1, matching t0 taken at the negedge after the request edge.
  typedef struct { logic [7:0] a; logic [31:0] d; int unsigned c; } wr_t;
  wr_t         log_q[$];
  int unsigned cyc_cnt = 0, done_cnt = 0, done_cyc = 0;

  always @(posedge clk_i) begin
    if (mix_stb_o && !mix_we_o) log_q.push_back('{a: mix_addr_o, d: mix_dat_o, c: cyc_cnt});
    if (frame_done_o) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc_cnt;
    end
    cyc_cnt <= cyc_cnt + 1;
  end

  int          n_checks = 0, n_fail = 0;
  int unsigned t0, d0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_wr(input string p, input int i, input logic [7:0] a,
                          input logic [31:0] d, input int rel);
    $display("wr %s: idx=%0d addr=%02h dat=%08h", p, i, log_q[i].a, log_q[i].d);
    check({p, "_addr"}, 32'(log_q[i].a), 32'(a));
    check({p, "_dat"}, log_q[i].d, d);
    if (rel >= 0) check({p, "_cyc"}, log_q[i].c - t0, rel);
  endtask

  // Pulse frame_req_i for one cycle (called at a negedge); t0 marks the sample edge.
  task automatic req_pulse();
    frame_req_i = 1'b1;
    @(negedge clk_i);
    frame_req_i = 1'b0;
    t0 = cyc_cnt;
  endtask

  initial begin
    rst_ni = 1'b0; en_i = 1'b1; frame_req_i = 1'b0; cmd_valid_i = 1'b0;
    cmd_addr_i = '0; cmd_dat_i = '0; model_dead = 1'b0;
    repeat (3) @(negedge clk_i);

    // Reset values
    check("rst_stb", 32'(mix_stb_o), 0);
    check("rst_we", 32'(mix_we_o), 1);
    check("rst_ready", 32'(cmd_ready_o), 1);
    check("rst_busy", 32'(busy_o), 0);
    check("rst_frames", 32'(frames_o), 0);
    check("rst_err", 32'(err_o), 0);
    rst_ni = 1'b1;
    @(negedge clk_i);

    // Single request, empty queue
    log_q.delete(); d0 = done_cnt;
    req_pulse();
    repeat (40) @(negedge clk_i);
    check("t1_nwr", log_q.size(), 3);
    check_wr("t1_w0", 0, MIX_REG_MADDR, BASE, 1);
    check_wr("t1_w1", 1, MIX_REG_MLEN, 32'd256, 3);
    check_wr("t1_w2", 2, MIX_REG_CTRL, 32'd1, 5);
    check("t1_ndone", done_cnt - d0, 1);
    check("t1_done_cyc", done_cyc - t0, 27);
    check("t1_frames", 32'(frames_o), 1);
    check("t1_half", 32'(frame_half_o), 1);
    check("t1_busy", 32'(busy_o), 0);

    // Second request targets the other half
    log_q.delete();
    req_pulse();
    repeat (40) @(negedge clk_i);
    check("t2_nwr", log_q.size(), 3);
    check_wr("t2_w0", 0, MIX_REG_MADDR, BASE + 32'd256, 1);
    check("t2_frames", 32'(frames_o), 2);
    check("t2_half", 32'(frame_half_o), 0);

    // Overrun: requests at relative cycles 0 and 2 during a running frame
    d0 = done_cnt;
    req_pulse();
    repeat (12) @(negedge clk_i);
    req_pulse();
    check("ovr_first", 32'(overrun_o), 0);
    @(negedge clk_i);
    req_pulse();
    check("ovr_second", 32'(overrun_o), 1);
    repeat (90) @(negedge clk_i);
    check("ovr_ndone", done_cnt - d0, 2);
    check("ovr_frames", 32'(frames_o), 4);

    // en_i low holds a pending request; raising it starts the frame
    en_i = 1'b0; d0 = done_cnt;
    req_pulse();
    repeat (10) @(negedge clk_i);
    check("en_busy", 32'(busy_o), 0);
    en_i = 1'b1;
    repeat (40) @(negedge clk_i);
    check("en_ndone", done_cnt - d0, 1);
    check("en_frames", 32'(frames_o), 5);
    check("en_half", 32'(frame_half_o), 1);

    // Queued commands drain before the pending frame; 0x05 is rejected
    log_q.delete();
    cmd_valid_i = 1'b1; cmd_addr_i = 8'h80; cmd_dat_i = 32'h1000; frame_req_i = 1'b1;
    @(negedge clk_i);
    frame_req_i = 1'b0; cmd_addr_i = 8'h81; cmd_dat_i = 32'd64;
    @(negedge clk_i);
    cmd_addr_i = 8'h92; cmd_dat_i = 32'h7F;
    @(negedge clk_i);
    cmd_addr_i = 8'h05; cmd_dat_i = 32'd1;
    @(negedge clk_i);
    cmd_valid_i = 1'b0;
    repeat (70) @(negedge clk_i);
    t0 = log_q.size() > 0 ? log_q[0].c : 0;
    check("cmd_nwr", log_q.size(), 6);
    check_wr("cmd_w0", 0, 8'h80, 32'h1000, -1);
    check_wr("cmd_w1", 1, 8'h81, 32'd64, 3);
    check_wr("cmd_w2", 2, 8'h92, 32'h7F, -1);
    check_wr("cmd_w3", 3, MIX_REG_MADDR, BASE + 32'd256, -1);
    check_wr("cmd_w4", 4, MIX_REG_MLEN, 32'd256, -1);
    check_wr("cmd_w5", 5, MIX_REG_CTRL, 32'd1, -1);
    check("cmd_err", 32'(err_o), 1);
    check("cmd_frames", 32'(frames_o), 6);
    check("cmd_half", 32'(frame_half_o), 0);

    // Asynchronous reset during WAIT_DONE with a full queue
    req_pulse();
    repeat (15) @(negedge clk_i);
    for (int i = 0; i < 4; i++) begin
      cmd_valid_i = 1'b1; cmd_addr_i = 8'(8'h80 + i); cmd_dat_i = 32'(i);
      @(negedge clk_i);
    end
    cmd_valid_i = 1'b0;
    check("full_ready", 32'(cmd_ready_o), 0);
    check("full_busy", 32'(busy_o), 1);
    #2 rst_ni = 1'b0;
    #1;
    check("arst_busy", 32'(busy_o), 0);
    check("arst_stb", 32'(mix_stb_o), 0);
    check("arst_we", 32'(mix_we_o), 1);
    check("arst_frames", 32'(frames_o), 0);
    check("arst_err", 32'(err_o), 0);
    check("arst_ovr", 32'(overrun_o), 0);
    check("arst_ready", 32'(cmd_ready_o), 1);
    @(negedge clk_i);
    rst_ni = 1'b1;
    log_q.delete(); d0 = done_cnt;
    repeat (20) @(negedge clk_i);
    check("arst_qempty", log_q.size(), 0);
    check("arst_ready2", 32'(cmd_ready_o), 1);
    check("arst_ndone", done_cnt - d0, 0);

    // Start timeout: the mixer never goes busy
    model_dead = 1'b1; log_q.delete(); d0 = done_cnt;
    req_pulse();
    repeat (10) @(negedge clk_i);
    check("tmo_err_early", 32'(err_o), 0);
    check("tmo_busy_early", 32'(busy_o), 1);
    @(negedge clk_i);
    check("tmo_err", 32'(err_o), 1);
    check("tmo_idle", 32'(busy_o), 0);
    repeat (20) @(negedge clk_i);
    check("tmo_nwr", log_q.size(), 3);
    check_wr("tmo_w0", 0, MIX_REG_MADDR, BASE, 1);
    check("tmo_ndone", done_cnt - d0, 0);
    check("tmo_frames", 32'(frames_o), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
